// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-add multiplier that borrows the shared 32-bit ALU
// The state and working registers select the ALU operands; each step's ALU result is captured on the edge that leaves the step.
module alu_mul_sequencer #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  iter;
  logic [31:0] product_q;
  logic        finish_shr;

  // alu_zero reflects the shifted multiplier, so it tells us whether any set bits remain.
  assign finish_shr = (EARLY_EXIT && alu_zero) || (iter == 6'd31);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      iter      <= '0;
      product_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            iter   <= '0;
          end
        end
        S_TEST: begin
          if (EARLY_EXIT && (mplier == 32'd0)) product_q <= acc;
        end
        S_ADD: acc <= alu_result;
        S_SHL: mcand <= alu_result;
        S_SHR: begin
          mplier <= alu_result;
          iter   <= iter + 6'd1;
          if (finish_shr) product_q <= acc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_TEST;
      end
      S_TEST: begin
        if (EARLY_EXIT && (mplier == 32'd0)) state_next = S_DONE;
        else if (mplier[0])                  state_next = S_ADD;
        else                                 state_next = S_SHL;
      end
      S_ADD: begin
        alu_a      = acc;
        alu_b      = mcand;
        state_next = S_SHL;
      end
      S_SHL: begin
        alu_a       = mcand;
        alu_b       = 32'd1;
        alu_control = ALU_SLL;
        state_next  = S_SHR;
      end
      S_SHR: begin
        alu_a       = mplier;
        alu_b       = 32'd1;
        alu_control = ALU_SRL;
        state_next  = finish_shr ? S_DONE : S_TEST;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - randomized self-checking bench for alu_mul_sequencer
// Two instances (early exit on/off) each drive their own behavioural ALU.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_ee = 1'b0;
  logic        start_ne = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;

  logic [31:0] res_ee, res_ne, alu_a_ee, alu_a_ne, alu_b_ee, alu_b_ne, prod_ee, prod_ne;
  logic [3:0]  ctl_ee, ctl_ne;
  logic        zero_ee, zero_ne, busy_ee, busy_ne, done_ee, done_ne;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] res_prod;
  int          res_lat;
  int          done_cnt;
  bit          busy_drop;
  logic        post_done, post_busy;
  logic [67:0] trace_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] c);
    case (c)
      4'b0011: return a + b;
      4'b0101: return a << b[4:0];
      4'b0110: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always_comb res_ee = alu_f(alu_a_ee, alu_b_ee, ctl_ee);
  always_comb res_ne = alu_f(alu_a_ne, alu_b_ne, ctl_ne);
  assign zero_ee = (res_ee == 32'd0);
  assign zero_ne = (res_ne == 32'd0);

  alu_mul_sequencer #(.EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .reset(reset), .start(start_ee), .op_a(op_a), .op_b(op_b),
    .alu_result(res_ee), .alu_zero(zero_ee), .alu_a(alu_a_ee), .alu_b(alu_b_ee),
    .alu_control(ctl_ee), .busy(busy_ee), .done(done_ee), .product(prod_ee)
  );

  alu_mul_sequencer #(.EARLY_EXIT(1'b0)) dut_ne (
    .clk(clk), .reset(reset), .start(start_ne), .op_a(op_a), .op_b(op_b),
    .alu_result(res_ne), .alu_zero(zero_ne), .alu_a(alu_a_ne), .alu_b(alu_b_ne),
    .alu_control(ctl_ne), .busy(busy_ne), .done(done_ne), .product(prod_ne)
  );

  // Latency from the multiplier's bit pattern: 3 steps per scanned bit plus an add per set bit.
  function automatic int exp_lat(bit ee, logic [31:0] b);
    int n;
    if (!ee) return 97 + $countones(b);
    if (b == 32'd0) return 2;
    n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return 1 + 3 * n + $countones(b);
  endfunction

  task automatic run_op(input bit ne, input logic [31:0] a, input logic [31:0] b, input int inject_at);
    int k;
    trace_q.delete();
    res_lat   = -1;
    res_prod  = '0;
    done_cnt  = 0;
    busy_drop = 0;
    k = 0;
    @(negedge clk);
    while ((ne ? busy_ne : busy_ee) && k < 300) begin
      @(negedge clk);
      k++;
    end
    op_a = a;
    op_b = b;
    if (ne) start_ne = 1'b1; else start_ee = 1'b1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        start_ee = 1'b0;
        start_ne = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
      end
      if (inject_at != 0 && e == inject_at) begin
        op_a = 32'd9;
        op_b = 32'd9;
        if (ne) start_ne = 1'b1; else start_ee = 1'b1;
      end
      if (inject_at != 0 && e == inject_at + 1) begin
        start_ee = 1'b0;
        start_ne = 1'b0;
      end
      trace_q.push_back(ne ? {ctl_ne, alu_a_ne, alu_b_ne} : {ctl_ee, alu_a_ee, alu_b_ee});
      if (!(ne ? busy_ne : busy_ee)) busy_drop = 1;
      if (ne ? done_ne : done_ee) begin
        done_cnt++;
        res_lat  = e;
        res_prod = ne ? prod_ne : prod_ee;
        break;
      end
    end
    @(posedge clk);
    #1;
    post_done = ne ? done_ne : done_ee;
    post_busy = ne ? busy_ne : busy_ee;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy_ee, done_ee, prod_ee, ctl_ee, alu_a_ee, alu_b_ee} !== {1'b0, 1'b0, 32'd0, 4'b0011, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_ee: busy=%b done=%b product=%h ctl=%b a=%h b=%h, required 0 0 0 0011 0 0",
               busy_ee, done_ee, prod_ee, ctl_ee, alu_a_ee, alu_b_ee);
    end
    vectors++;
    if ({busy_ne, done_ne, prod_ne, ctl_ne, alu_a_ne, alu_b_ne} !== {1'b0, 1'b0, 32'd0, 4'b0011, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_ne: busy=%b done=%b product=%h ctl=%b a=%h b=%h, required 0 0 0 0011 0 0",
               busy_ne, done_ne, prod_ne, ctl_ne, alu_a_ne, alu_b_ne);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul_zero();
    run_op(1'b0, 32'h12345678, 32'd0, 0);
    vectors++;
    if (res_lat !== 2 || res_prod !== 32'd0) begin
      miscompares++;
      $display("FAIL mul_zero: lat=%0d product=%h, required lat=2 product=0", res_lat, res_prod);
    end
    foreach (trace_q[i]) begin
      vectors++;
      if (trace_q[i][67:64] !== 4'b0011) begin
        miscompares++;
        $display("FAIL mul_zero_ctl[%0d]: ctl=%b, required 0011", i, trace_q[i][67:64]);
      end
    end
  endtask

  task automatic test_small();
    logic [3:0]  exp_c[13] = '{4'h3, 4'h3, 4'h5, 4'h6, 4'h3, 4'h3, 4'h5, 4'h6, 4'h3, 4'h3, 4'h5, 4'h6, 4'h3};
    logic [31:0] exp_a[13] = '{0, 0, 6, 7, 0, 6, 12, 3, 0, 18, 24, 1, 0};
    logic [31:0] exp_b[13] = '{0, 6, 1, 1, 0, 12, 1, 1, 0, 24, 1, 1, 0};
    run_op(1'b0, 32'd6, 32'd7, 0);
    vectors++;
    if (res_lat !== 13 || res_prod !== 32'd42) begin
      miscompares++;
      $display("FAIL small: lat=%0d product=%0d, required lat=13 product=42", res_lat, res_prod);
    end
    vectors++;
    if (trace_q.size() != 13) begin
      miscompares++;
      $display("FAIL small_trace_len: got %0d cycles, required 13", trace_q.size());
    end else begin
      for (int i = 0; i < 13; i++) begin
        vectors++;
        if (trace_q[i] !== {exp_c[i], exp_a[i], exp_b[i]}) begin
          miscompares++;
          $display("FAIL small_alu[%0d]: got %h, required %h", i, trace_q[i], {exp_c[i], exp_a[i], exp_b[i]});
        end
      end
    end
  endtask

  task automatic test_max();
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    vectors++;
    if (res_lat !== 129 || res_prod !== 32'd1) begin
      miscompares++;
      $display("FAIL max: lat=%0d product=%h, required lat=129 product=1", res_lat, res_prod);
    end
    vectors++;
    if (busy_drop !== 1'b0 || post_busy !== 1'b0 || post_done !== 1'b0) begin
      miscompares++;
      $display("FAIL max_busy: drop=%b post_busy=%b post_done=%b, required 0 0 0", busy_drop, post_busy, post_done);
    end
  endtask

  task automatic test_start_while_busy();
    int extra;
    run_op(1'b0, 32'd3, 32'd5, 4);
    vectors++;
    if (res_prod !== 32'd15 || res_lat !== exp_lat(1'b1, 32'd5) || done_cnt != 1) begin
      miscompares++;
      $display("FAIL busy_start: product=%0d lat=%0d dones=%0d, required 15 %0d 1", res_prod, res_lat, exp_lat(1'b1, 32'd5), done_cnt);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy_ee || done_ee) extra++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (extra != 0 || post_done !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_ignored: active cycles after done=%0d post_done=%b, required 0 0", extra, post_done);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    @(negedge clk);
    op_a = 32'hFFFF;
    op_b = 32'hFFFF;
    start_ee = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      start_ee = 1'b0;
      if (done_ee) dones++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({busy_ee, done_ee, prod_ee, ctl_ee} !== {1'b0, 1'b0, 32'd0, 4'b0011}) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b product=%h ctl=%b, required 0 0 0 0011", busy_ee, done_ee, prod_ee, ctl_ee);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done_ee || busy_ee) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_done: got %0d active/done cycles, required 0", dones);
    end
    run_op(1'b0, 32'd2, 32'd3, 0);
    vectors++;
    if (res_prod !== 32'd6) begin
      miscompares++;
      $display("FAIL reset_mid_after: product=%0d, required 6", res_prod);
    end
  endtask

  task automatic test_no_early_exit();
    run_op(1'b1, 32'hFFFFFFFD, 32'd5, 0);
    vectors++;
    if (res_lat !== 99 || res_prod !== 32'hFFFFFFF1) begin
      miscompares++;
      $display("FAIL no_early_exit: lat=%0d product=%h, required lat=99 product=fffffff1", res_lat, res_prod);
    end
    run_op(1'b1, 32'h1234, 32'd0, 0);
    vectors++;
    if (res_lat !== 97 || res_prod !== 32'd0) begin
      miscompares++;
      $display("FAIL no_early_exit_zero: lat=%0d product=%h, required lat=97 product=0", res_lat, res_prod);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, ex;
    for (int i = 0; i < 24; i++) begin
      bit ne;
      ne = (i % 3 == 2);
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      if (i % 8 == 5) b = 32'd0;
      ex = a * b;
      run_op(ne, a, b, 0);
      vectors++;
      if (res_prod !== ex || res_lat !== exp_lat(!ne, b) || post_done !== 1'b0) begin
        miscompares++;
        $display("FAIL random[%0d] ee=%b a=%h b=%h: product=%h lat=%0d post_done=%b, required %h %0d 0",
                 i, !ne, a, b, res_prod, res_lat, post_done, ex, exp_lat(!ne, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom_range(1, 255);
      run_op(1'b0, a, b, 0);
      vectors++;
      if (res_prod !== a * b || res_lat !== exp_lat(1'b1, b) || post_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: product=%h lat=%0d post_busy=%b, required %h %0d 0",
                 i, res_prod, res_lat, post_busy, a * b, exp_lat(1'b1, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_zero();
    test_small();
    test_max();
    test_start_while_busy();
    test_reset_mid();
    test_no_early_exit();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Iterative shift-add multiplier controller that time-shares the single-cycle 32-bit ALU. It returns the low 32 bits of op_a × op_b, which are the same for signed and unsigned operands. It sits beside the ALU and drives the ALU operand and control inputs whenever it is busy. The ALU's combinational result and zero flag come back to this block and are captured at each clock edge.

## Interface
- EARLY_EXIT, default 1: when 1, terminate as soon as the remaining multiplier is zero. When 0, always run 32 iterations.
- clk  input  1  system clock. The block has one clock; all state updates on the rising edge.
- reset  input  1  reset is synchronous and active-high.
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  32  multiplicand; latched when start is accepted.
- op_b  input  32  multiplier; latched when start is accepted.
- alu_result  input  32  ALU result for the current alu_a/alu_b/alu_control.
- alu_zero  input  1  ALU zero flag (alu_result == 0).
- alu_a  output  32  ALU operand a.
- alu_b  output  32  ALU operand b.
- alu_control  output  4  ALU op: 4'b0011 add, 4'b0101 sll, 4'b0110 srl.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; product is valid while done is high.
- product  output  32  registered result; holds its value until the next completion or reset.

## Operation
- Internal registers:
  - acc, mcand, mplier: 32 bits each.
  - iter: 6-bit counter.
  - product_q: 32 bits.
- States: IDLE, TEST, ADD, SHL, SHR, DONE.
- IDLE
  - alu_a=0, alu_b=0, alu_control=0011.
  - If start=1, load acc=0, mcand=op_a, mplier=op_b, iter=0, and go to TEST.
- TEST
  - ALU outputs are the same as in IDLE.
  - EARLY_EXIT=1 and mplier==0: load product_q=acc and go to DONE.
  - Otherwise, mplier[0]=1: go to ADD.
  - Otherwise: go to SHL.
- ADD
  - alu_a=acc, alu_b=mcand, alu_control=0011.
  - acc<=alu_result, wrapping modulo 2^32.
  - Go to SHL.
- SHL
  - alu_a=mcand, alu_b=1, alu_control=0101.
  - mcand<=alu_result.
  - Go to SHR.
- SHR
  - alu_a=mplier, alu_b=1, alu_control=0110.
  - mplier<=alu_result and iter<=iter+1.
  - Go to DONE, loading product_q=acc, if either (EARLY_EXIT=1 and alu_zero=1) or iter==31.
  - Otherwise go to TEST.
- DONE
  - done=1, busy=1; ALU outputs are the same as in IDLE.
  - Go to IDLE unconditionally.
- start is ignored in every state except IDLE, including DONE. Operands latched at acceptance are unaffected by later changes to op_a/op_b.
- Reset values:
  - state=IDLE, busy=0, done=0, product=0.
  - alu_a=0, alu_b=0, alu_control=4'b0011.
  - acc, mcand, mplier and iter all reset to 0.
- Reset mid-operation aborts the operation. The next cycle shows the reset values, and no done pulse is generated for the aborted operation.

## Timing
- ALU outputs are a combinational function of the state and the internal registers. The ALU result is captured at the same edge that leaves ADD, SHL or SHR.
- Latency L is the number of rising edges from the edge that samples start=1 to the edge after which done=1.
- EARLY_EXIT=1:
  - op_b=0 gives L=2.
  - Otherwise L = 1 + 3n + popcount(op_b), where n is the index of the highest set bit of op_b plus 1.
- EARLY_EXIT=0: L = 1 + 96 + popcount(op_b). The maximum is 129.
- done is high for exactly one cycle. busy falls in the cycle after done.
- The earliest acceptance of a new start is the cycle after done.
- Back-to-back operations therefore have a minimum of one IDLE cycle between them.

## Test plan
- Multiply by zero: reset, then start with op_a=0x12345678, op_b=0.
  - Required: done=1 two cycles after start; product=0x00000000.
  - Required: alu_control stays 0011 throughout.
- Small operands: op_a=6, op_b=7 with EARLY_EXIT=1.
  - Required: done at L=13 and product=42.
  - Required: the ALU sequence is ADD, SHL, SHR repeated three times.
- Maximum operands: op_a=op_b=0xFFFFFFFF.
  - Required: product=0x00000001, L=129.
  - Required: busy is high continuously until the cycle after done.
- Start while busy: op_a=3, op_b=5, then start pulsed with op_a=9, op_b=9 at cycle 4 of the operation.
  - Required: product=15 and exactly one done pulse.
  - Required: the second start is not accepted.
- Reset mid-operation: assert reset at cycle 6 of 0xFFFF×0xFFFF.
  - Required: the next cycle shows busy=0, done=0, product=0 and alu_control=0011.
  - Required: a following 2×3 returns 6.
- No early exit: EARLY_EXIT=0, op_a=0xFFFFFFFD (−3), op_b=5.
  - Required: product=0xFFFFFFF1 (−15) with L=99.
